// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers at byte offsets 4*k.
// Define AXIL_REG_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module axil_reg_slave #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic [31:0] regs [NUM_REGS];

    w_state_t   w_state, w_state_next;
    logic       aw_ready, w_ready, b_valid;
    logic       aw_ready_next, w_ready_next;
    logic [1:0] b_resp;
    logic       aw_hs, w_hs, commit;
    logic [IDX_W-1:0] aw_idx_q, commit_idx;
    logic [31:0]      w_data_q, commit_data;
    logic [3:0]       w_strb_q, commit_strb;

    r_state_t   r_state, r_state_next;
    logic       ar_ready, r_valid, ar_hs;
    logic [31:0] r_data, rd_word;
    logic [1:0]  r_resp;
    logic [IDX_W-1:0] ar_idx;

    logic [1:0] wr_resp, rd_resp;
    logic       unused_ok;

    assign aw_hs  = S_AXI_AWVALID && aw_ready;
    assign w_hs   = S_AXI_WVALID && w_ready;
    assign ar_hs  = S_AXI_ARVALID && ar_ready;
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

`ifdef AXIL_REG_SLVERR_EN
    function automatic logic [1:0] slverr_for(input logic [IDX_W-1:0] idx);
        return ({{(32-IDX_W){1'b0}}, idx} < 32'(NUM_REGS)) ? 2'b00 : 2'b10;
    endfunction
    assign wr_resp = slverr_for(commit_idx);
    assign rd_resp = slverr_for(ar_idx);
`else
    assign wr_resp = 2'b00;
    assign rd_resp = 2'b00;
`endif

    // Commit uses whichever half arrives now together with the half latched earlier.
    always_comb begin
        w_state_next = w_state;
        commit       = 1'b0;
        commit_idx   = aw_idx_q;
        commit_data  = w_data_q;
        commit_strb  = w_strb_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_next = W_RESP;
                    commit       = 1'b1;
                    commit_idx   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    commit_data  = S_AXI_WDATA;
                    commit_strb  = S_AXI_WSTRB;
                end else if (aw_hs) begin
                    w_state_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_state_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    w_state_next = W_RESP;
                    commit       = 1'b1;
                    commit_data  = S_AXI_WDATA;
                    commit_strb  = S_AXI_WSTRB;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    w_state_next = W_RESP;
                    commit       = 1'b1;
                    commit_idx   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
            end
            W_RESP: begin
                if (b_valid && S_AXI_BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
        aw_ready_next = (w_state_next == W_IDLE) || (w_state_next == W_HAVE_W);
        w_ready_next  = (w_state_next == W_IDLE) || (w_state_next == W_HAVE_AW);
    end

    // Handshake outputs are registered so no input reaches an output combinationally.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= 2'b00;
        end else begin
            w_state  <= w_state_next;
            aw_ready <= aw_ready_next;
            w_ready  <= w_ready_next;
            b_valid  <= (w_state_next == W_RESP);
            if (commit) b_resp <= wr_resp;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
        end
    end

    // Unmapped indices match no register, so they never update anything.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= 32'h0;
        end else if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit_idx == IDX_W'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (commit_strb[b]) regs[k][8*b +: 8] <= commit_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = 32'h0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDX_W'(k)) rd_word = regs[k];
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = R_RESP;
            R_RESP:  if (r_valid && S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read capture samples the register file before any same-edge write lands.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= 32'h0;
            r_resp   <= 2'b00;
        end else begin
            r_state  <= r_state_next;
            ar_ready <= (r_state_next == R_IDLE);
            r_valid  <= (r_state_next == R_RESP);
            if (ar_hs) begin
                r_data <= rd_word;
                r_resp <= rd_resp;
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = r_resp;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: vector table plus hand-built handshake corner cases.
// Unmapped-response expectations follow AXIL_REG_SLVERR_EN when it is defined.
module tb_axil_reg_slave;

`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    axil_reg_slave #(.C_S_AXI_ADDR_WIDTH(6), .NUM_REGS(4)) dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),  .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),  .S_AXI_RREADY(rready)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_pend, w_pend, aw_go, w_go;
        int cyc;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; cyc = 0;
        while ((aw_pend || w_pend) && cyc < 20) begin
            aw_go = aw_pend && awready;
            w_go  = w_pend && wready;
            tick(); cyc++;
            if (aw_go) begin aw_pend = 1'b0; awvalid = 1'b0; end
            if (w_go)  begin w_pend  = 1'b0; wvalid  = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        cyc = 0;
        while (!bvalid && cyc < 20) begin tick(); cyc++; end
        check("bvalid_arrives", bvalid, 1'b1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic go;
        int cyc;
        araddr = a; arvalid = 1'b1; cyc = 0; go = 1'b0;
        while (!go && cyc < 20) begin
            go = arready;
            tick(); cyc++;
        end
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 20) begin tick(); cyc++; end
        check("rvalid_arrives", rvalid, 1'b1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    function automatic vec_t mk(input string n, input logic wr, input logic [5:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                input logic [31:0] ed, input logic [1:0] er);
        vec_t v;
        v.name = n; v.wr = wr; v.addr = a; v.data = d; v.strb = s;
        v.exp_data = ed; v.exp_resp = er;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;

        vq.push_back(mk("wr_r0",      1, 6'h00, 32'h1,        4'hF, 32'h0,        2'b00));
        vq.push_back(mk("wr_r1",      1, 6'h04, 32'h2,        4'hF, 32'h0,        2'b00));
        vq.push_back(mk("wr_r2",      1, 6'h08, 32'h3,        4'hF, 32'h0,        2'b00));
        vq.push_back(mk("wr_r3",      1, 6'h0C, 32'h4,        4'hF, 32'h0,        2'b00));
        vq.push_back(mk("rd_r0",      0, 6'h00, 32'h0,        4'h0, 32'h1,        2'b00));
        vq.push_back(mk("rd_r1",      0, 6'h04, 32'h0,        4'h0, 32'h2,        2'b00));
        vq.push_back(mk("rd_r2",      0, 6'h08, 32'h0,        4'h0, 32'h3,        2'b00));
        vq.push_back(mk("rd_r3",      0, 6'h0C, 32'h0,        4'h0, 32'h4,        2'b00));
        vq.push_back(mk("wr_r0_ones", 1, 6'h00, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00));
        vq.push_back(mk("wr_r0_strb", 1, 6'h00, 32'h12345678, 4'h5, 32'h0,        2'b00));
        vq.push_back(mk("rd_r0_strb", 0, 6'h00, 32'h0,        4'h0, 32'hFF34FF78, 2'b00));
        vq.push_back(mk("wr_unmap",   1, 6'h10, 32'hAA,       4'hF, 32'h0,        UNMAP_RESP));
        vq.push_back(mk("rd_unmap",   0, 6'h10, 32'h0,        4'h0, 32'h0,        UNMAP_RESP));
        vq.push_back(mk("rd_lowbits", 0, 6'h01, 32'h0,        4'h0, 32'hFF34FF78, 2'b00));
        vq.push_back(mk("rd_top",     0, 6'h3C, 32'h0,        4'h0, 32'h0,        UNMAP_RESP));
        vq.push_back(mk("wr_r1_b3",   1, 6'h06, 32'hDEADBEEF, 4'h8, 32'h0,        2'b00));
        vq.push_back(mk("rd_r1_b3",   0, 6'h04, 32'h0,        4'h0, 32'hDE000002, 2'b00));
        vq.push_back(mk("rd_r2_keep", 0, 6'h08, 32'h0,        4'h0, 32'h3,        2'b00));
        vq.push_back(mk("rd_r3_keep", 0, 6'h0C, 32'h0,        4'h0, 32'h4,        2'b00));

        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state, then readies one cycle after release
        repeat (3) @(posedge clk);
        #1;
        check("rst_readies", {29'b0, awready, wready, arready}, 32'h0);
        check("rst_valids",  {30'b0, bvalid, rvalid}, 32'h0);
        check("rst_rdata",   rdata, 32'h0);
        check("rst_resps",   {28'b0, bresp, rresp}, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_readies", {29'b0, awready, wready, arready}, 32'h7);

        foreach (vq[i]) begin
            if (vq[i].wr) begin
                axi_write(vq[i].addr, vq[i].data, vq[i].strb, rs);
                check({vq[i].name, "_bresp"}, rs, vq[i].exp_resp);
            end else begin
                axi_read(vq[i].addr, rd, rs);
                check({vq[i].name, "_rdata"}, rd, vq[i].exp_data);
                check({vq[i].name, "_rresp"}, rs, vq[i].exp_resp);
            end
        end

        // W leads AW by three cycles; latched data must be used, then B stalls
        wdata = 32'h0000CAFE; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0; wdata = 32'hBAD0BAD0; wstrb = 4'h0;
        check("havew_readies", {30'b0, awready, wready}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            check("havew_no_bvalid", bvalid, 1'b0);
            tick();
        end
        awaddr = 6'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("bvalid_after_aw", bvalid, 1'b1);
        awaddr = 6'h0C; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bstall_bvalid",  bvalid, 1'b1);
            check("bstall_bresp",   bresp, 2'b00);
            check("bstall_readies", {30'b0, awready, wready}, 32'h0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bdone_bvalid",  bvalid, 1'b0);
        check("bdone_readies", {30'b0, awready, wready}, 32'h3);
        axi_read(6'h08, rd, rs);
        check("rd_r2_cafe", rd, 32'h0000CAFE);
        axi_read(6'h0C, rd, rs);
        check("rd_r3_no_stray", rd, 32'h4);

        // R stall: data held, no second AR accepted
        araddr = 6'h08; arvalid = 1'b1;
        tick();
        araddr = 6'h0C;
        check("rvalid_latency", rvalid, 1'b1);
        check("r_first_data",   rdata, 32'h0000CAFE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstall_rvalid",  rvalid, 1'b1);
            check("rstall_rdata",   rdata, 32'h0000CAFE);
            check("rstall_arready", arready, 1'b0);
        end
        arvalid = 1'b0; rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rdone_rvalid",  rvalid, 1'b0);
        check("rdone_arready", arready, 1'b1);

        // Read and write of reg3 on the same edge: read sees the old value
        awaddr = 6'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h0C; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_edge_rdata",  rdata, 32'h4);
        check("same_edge_bvalid", bvalid, 1'b1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        axi_read(6'h0C, rd, rs);
        check("rd_r3_new", rd, 32'h55);

        // Reset between AW and W discards the pending write
        awaddr = 6'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("haveaw_awready", awready, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst2_readies", {29'b0, awready, wready, arready}, 32'h7);
        check("rst2_bvalid",  bvalid, 1'b0);
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check("rst2_w_only_no_bvalid", bvalid, 1'b0);
        axi_read(6'h00, rd, rs);
        check("rst2_r0_zero", rd, 32'h0);
        check("rst2_r0_resp", rs, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
